floor_request_scheduler: RTL and testbench

//   N-floor request bank with a SCAN direction/target scheduler: one request bit per floor.

---
 rtl/floor_request_scheduler.sv | 96 +++++++++
 tb/tb_floor_request_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/floor_request_scheduler.sv
// floor_request_scheduler: per-floor request bank with a SCAN direction/target scheduler
module floor_request_scheduler #(
  parameter int NUM_FLOORS = 6,
  parameter int KEY_W = 3,
  localparam int FW = $clog2(NUM_FLOORS),
  localparam int CW = $clog2(NUM_FLOORS + 1)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [KEY_W-1:0]      KEY,
  input  logic [FW-1:0]         cur_floor,
  input  logic                  Done,
  input  logic [FW-1:0]         done_floor,
  output logic [NUM_FLOORS-1:0] floor,
  output logic [1:0]            dir,
  output logic [FW-1:0]         target,
  output logic                  target_valid,
  output logic [CW-1:0]         req_count
);
  typedef enum logic [1:0] {IDLE = 2'b00, UP = 2'b01, DOWN = 2'b10} dir_e;
  localparam logic [KEY_W-1:0] KEY_MAX = KEY_W'(NUM_FLOORS);
  localparam logic [FW:0] NF = (FW + 1)'(NUM_FLOORS);
  logic [KEY_W-1:0] key_q;
  logic [NUM_FLOORS-1:0] floor_q, floor_d;
  logic [CW-1:0] cnt_q, cnt_d;
  dir_e dir_q, dir_d;
  logic [FW-1:0] target_q, target_d, up_t, dn_t;
  logic tv_q, tv_d;
  logic accept, above, below, here, cur_ok;
  assign accept = KEY != key_q && KEY != '0 && KEY <= KEY_MAX;
  assign cur_ok = {1'b0, cur_floor} < NF;
  // Request bank update: key sets, Done clears (clear wins on the same floor), count follows
  always_comb begin
    floor_d = floor_q;
    cnt_d = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (accept && KEY == KEY_W'(i + 1)) floor_d[i] = 1'b1;
      if (Done && done_floor == FW'(i)) floor_d[i] = 1'b0;
      cnt_d = cnt_d + CW'(floor_d[i]);
    end
  end
  // Classify pending requests relative to the car: nearest above, nearest below, at car
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    here = 1'b0;
    up_t = '0;
    dn_t = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--)
      if (floor_q[i] && FW'(i) > cur_floor) begin
        above = 1'b1;
        up_t = FW'(i);
      end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (floor_q[i] && FW'(i) < cur_floor) begin
        below = 1'b1;
        dn_t = FW'(i);
      end
      if (floor_q[i] && FW'(i) == cur_floor) here = 1'b1;
    end
  end
  // Next direction and target; UP wins a tie from IDLE, a car outside the shaft idles
  always_comb begin
    dir_d = IDLE;
    if (cur_ok)
      case (dir_q)
        UP:      dir_d = above ? UP : below ? DOWN : IDLE;
        DOWN:    dir_d = below ? DOWN : above ? UP : IDLE;
        default: dir_d = here ? IDLE : above ? UP : below ? DOWN : IDLE;
      endcase
    target_d = !cur_ok ? '0 : dir_d == UP ? up_t : dir_d == DOWN ? dn_t : cur_floor;
    tv_d = cur_ok && (dir_d != IDLE || here);
  end
  // State registers; key_q tracks through reset so a key held across reset never registers
  always_ff @(posedge Clock) begin
    key_q <= KEY;
    if (Reset) begin
      floor_q <= '0;
      cnt_q <= '0;
      dir_q <= IDLE;
      target_q <= '0;
      tv_q <= 1'b0;
    end else begin
      floor_q <= floor_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      target_q <= target_d;
      tv_q <= tv_d;
    end
  end
  assign floor = floor_q;
  assign dir = dir_q;
  assign target = target_q;
  assign target_valid = tv_q;
  assign req_count = cnt_q;
endmodule

// File: tb/tb_floor_request_scheduler.sv
// tb_floor_request_scheduler: directed and random stimulus against a scoreboarded reference model
module tb_floor_request_scheduler;
  logic Clock, Reset, Done;
  logic [2:0] KEY, cur_floor, done_floor;
  logic [5:0] floor;
  logic [1:0] dir;
  logic [2:0] target, req_count;
  logic target_valid;
  typedef struct packed {
    logic [5:0] f;
    logic [2:0] c;
    logic [1:0] d;
    logic [2:0] t;
    logic       v;
  } exp_t;
  exp_t sb[$];
  logic [5:0] m_floor;
  logic [1:0] m_dir;
  logic [2:0] m_target, m_key;
  logic m_tv;
  int n_vec, n_err;
  floor_request_scheduler #(.NUM_FLOORS(6), .KEY_W(3)) dut (
    .Clock(Clock), .Reset(Reset), .KEY(KEY), .cur_floor(cur_floor), .Done(Done),
    .done_floor(done_floor), .floor(floor), .dir(dir), .target(target),
    .target_valid(target_valid), .req_count(req_count)
  );
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    exp_t e;
    logic [5:0] nf;
    logic [1:0] nd;
    logic [2:0] t;
    logic v;
    bit ab, be, he;
    int cur;
    cur = int'(cur_floor);
    ab = 0;
    be = 0;
    he = 0;
    nf = m_floor;
    if (KEY != m_key && KEY >= 1 && KEY <= 6) nf[KEY-1] = 1'b1;
    if (Done && done_floor < 6) nf[done_floor] = 1'b0;
    for (int i = 0; i < 6; i++)
      if (m_floor[i]) begin
        if (i > cur) ab = 1;
        if (i < cur) be = 1;
        if (i == cur) he = 1;
      end
    nd = 2'b00;
    t = 3'd0;
    v = 1'b0;
    if (cur < 6) begin
      case (m_dir)
        2'b01:   nd = ab ? 2'b01 : be ? 2'b10 : 2'b00;
        2'b10:   nd = be ? 2'b10 : ab ? 2'b01 : 2'b00;
        default: nd = he ? 2'b00 : ab ? 2'b01 : be ? 2'b10 : 2'b00;
      endcase
      if (nd == 2'b01) begin
        for (int i = cur + 1; i < 6; i++)
          if (m_floor[i]) begin t = 3'(i); break; end
        v = 1'b1;
      end else if (nd == 2'b10) begin
        for (int i = cur - 1; i >= 0; i--)
          if (m_floor[i]) begin t = 3'(i); break; end
        v = 1'b1;
      end else begin
        t = 3'(cur);
        v = he;
      end
    end
    if (Reset) begin
      nf = '0;
      nd = 2'b00;
      t = 3'd0;
      v = 1'b0;
    end
    m_key = KEY;
    m_floor = nf;
    m_dir = nd;
    m_target = t;
    m_tv = v;
    e = '{nf, 3'($countones(nf)), nd, t, v};
    sb.push_back(e);
    @(posedge Clock);
    #1;
    e = sb.pop_front();
    check("sb_floor", 8'(floor), 8'(e.f));
    check("sb_count", 8'(req_count), 8'(e.c));
    check("sb_dir", 8'(dir), 8'(e.d));
    check("sb_target", 8'(target), 8'(e.t));
    check("sb_valid", 8'(target_valid), 8'(e.v));
  endtask
  initial begin
    n_vec = 0;
    n_err = 0;
    Reset = 1'b1;
    KEY = 3'd3;
    cur_floor = 3'd0;
    Done = 1'b0;
    done_floor = 3'd0;
    m_key = KEY;
    m_floor = '0;
    m_dir = '0;
    m_target = '0;
    m_tv = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    tick();
    tick();
    check("rst_key_floor", 8'(floor), 8'h00);
    check("rst_key_dir", 8'(dir), 8'h0);
    check("rst_key_valid", 8'(target_valid), 8'h0);
    KEY = 3'd0;
    tick();
    KEY = 3'd4;
    tick();
    check("hold_floor", 8'(floor), 8'(6'b001000));
    check("hold_count", 8'(req_count), 8'd1);
    tick();
    check("hold_dir", 8'(dir), 8'h1);
    check("hold_target", 8'(target), 8'd3);
    tick();
    tick();
    tick();
    check("hold_once", 8'(req_count), 8'd1);
    KEY = 3'd0;
    Done = 1'b1;
    done_floor = 3'd3;
    tick();
    Done = 1'b0;
    tick();
    check("clr_dir", 8'(dir), 8'h0);
    check("clr_valid", 8'(target_valid), 8'h0);
    cur_floor = 3'd2;
    KEY = 3'd5;
    tick();
    KEY = 3'd6;
    tick();
    KEY = 3'd1;
    tick();
    KEY = 3'd0;
    tick();
    check("scan_dir_up", 8'(dir), 8'h1);
    check("scan_t4", 8'(target), 8'd4);
    Done = 1'b1;
    done_floor = 3'd4;
    tick();
    Done = 1'b0;
    tick();
    check("scan_t5", 8'(target), 8'd5);
    Done = 1'b1;
    done_floor = 3'd5;
    tick();
    Done = 1'b0;
    tick();
    check("scan_dir_down", 8'(dir), 8'h2);
    check("scan_t0", 8'(target), 8'd0);
    Done = 1'b1;
    done_floor = 3'd0;
    tick();
    Done = 1'b0;
    tick();
    check("scan_idle", 8'(dir), 8'h0);
    check("scan_invalid", 8'(target_valid), 8'h0);
    KEY = 3'd3;
    Done = 1'b1;
    done_floor = 3'd2;
    tick();
    check("same_floor_clear", 8'(floor), 8'h00);
    KEY = 3'd0;
    Done = 1'b0;
    tick();
    KEY = 3'd2;
    Done = 1'b1;
    done_floor = 3'd2;
    tick();
    check("diff_floor_both", 8'(floor), 8'(6'b000010));
    KEY = 3'd0;
    Done = 1'b0;
    tick();
    Done = 1'b1;
    done_floor = 3'd1;
    tick();
    Done = 1'b0;
    tick();
    tick();
    cur_floor = 3'd3;
    KEY = 3'd4;
    tick();
    KEY = 3'd0;
    tick();
    tick();
    check("here_dir", 8'(dir), 8'h0);
    check("here_target", 8'(target), 8'd3);
    check("here_valid", 8'(target_valid), 8'h1);
    KEY = 3'd2;
    tick();
    KEY = 3'd0;
    tick();
    tick();
    check("here_stays_idle", 8'(dir), 8'h0);
    Done = 1'b1;
    done_floor = 3'd3;
    tick();
    Done = 1'b0;
    tick();
    check("here_then_down", 8'(dir), 8'h2);
    check("here_then_t1", 8'(target), 8'd1);
    Done = 1'b1;
    done_floor = 3'd1;
    tick();
    Done = 1'b0;
    tick();
    tick();
    cur_floor = 3'd0;
    KEY = 3'd3;
    tick();
    KEY = 3'd0;
    tick();
    cur_floor = 3'd6;
    KEY = 3'd7;
    Done = 1'b1;
    done_floor = 3'd7;
    tick();
    Done = 1'b0;
    tick();
    check("oor_floor", 8'(floor), 8'(6'b000100));
    check("oor_dir", 8'(dir), 8'h0);
    check("oor_valid", 8'(target_valid), 8'h0);
    check("oor_target", 8'(target), 8'd0);
    cur_floor = 3'd1;
    KEY = 3'd5;
    tick();
    KEY = 3'd0;
    Reset = 1'b1;
    tick();
    check("midrst_floor", 8'(floor), 8'h00);
    check("midrst_count", 8'(req_count), 8'd0);
    check("midrst_dir", 8'(dir), 8'h0);
    Reset = 1'b0;
    for (int k = 0; k < 300; k++) begin
      KEY = ($urandom_range(0, 2) == 0) ? KEY : 3'($urandom_range(0, 7));
      Done = ($urandom_range(0, 3) == 0);
      done_floor = 3'($urandom_range(0, 7));
      cur_floor = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : cur_floor;
      Reset = ($urandom_range(0, 60) == 0);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
